// File: rtl/ccsds123_pkg.sv
// Shared types and defaults for the CCSDS-123 output buffer.
// ccsds123_word_t is the stored FIFO entry: packed bitstream word plus its last flag.
package ccsds123_pkg;

    localparam int CCSDS123_BUS_WIDTH    = 64;
    localparam int CCSDS123_DEPTH        = 16;
    localparam int CCSDS123_AFULL_MARGIN = 4;

    typedef struct packed {
        logic                          last;
        logic [CCSDS123_BUS_WIDTH-1:0] data;
    } ccsds123_word_t;

    // Pointer width for a power-of-two depth; never narrower than one bit.
    function automatic int ccsds123_ptr_w(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/ccsds123_fifo_mem.sv
// Register-file storage for the output FIFO: synchronous write, asynchronous read.
// Contents are intentionally not reset.
module ccsds123_fifo_mem #(
    parameter int W     = 65,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [W-1:0]  i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [W-1:0]  o_rdata
);

    logic [W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/ccsds123_out_fifo.sv
// Output buffer after ccsds123_top: absorbs the un-throttled word stream and replays it
// as an AXI-Stream master with fill/overflow/frame reporting. Define CCSDS123_OUT_BYTE_SWAP_EN
// to byte-reverse m_axis_tdata for little-endian DMA.
module ccsds123_out_fifo
    import ccsds123_pkg::*;
#(
    parameter int BUS_WIDTH    = CCSDS123_BUS_WIDTH,
    parameter int DEPTH        = CCSDS123_DEPTH,
    parameter int AFULL_MARGIN = CCSDS123_AFULL_MARGIN,
    parameter int CNT_W        = 32
) (
    input  logic                   clk,
    input  logic                   aresetn,
    input  logic [BUS_WIDTH-1:0]   in_data,
    input  logic                   in_valid,
    input  logic                   in_last,
    output logic [BUS_WIDTH-1:0]   m_axis_tdata,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic                   m_axis_tlast,
    output logic                   almost_full,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow,
    output logic                   done,
    output logic [CNT_W-1:0]       frame_words
);

    localparam int              AW        = ccsds123_ptr_w(DEPTH);
    localparam int              LW        = $clog2(DEPTH) + 1;
    localparam logic [LW-1:0]   L_FULL    = LW'(DEPTH);
    localparam logic [LW-1:0]   L_AFULL   = LW'(DEPTH - AFULL_MARGIN);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [0:0]      ST_STREAM = 1'b0;
    localparam logic [0:0]      ST_DRAIN  = 1'b1;

    typedef struct packed {
        logic                 last;
        logic [BUS_WIDTH-1:0] data;
    } word_t;

    logic [AW-1:0]    r_wptr, r_rptr;
    logic [LW-1:0]    r_level, r_pend, w_pend_nxt;
    logic [CNT_W-1:0] r_cur, r_frame_words;
    logic [0:0]       r_state;
    logic             r_afull, r_ovf, r_done;
    logic             w_rd, w_wr, w_drop, w_last_rd;
    word_t            w_wword, w_rword;

    assign w_rd      = (r_level != '0) && m_axis_tready;
    assign w_wr      = in_valid && ((r_level != L_FULL) || w_rd);
    assign w_drop    = in_valid && !w_wr;
    assign w_last_rd = w_rd && w_rword.last;
    assign w_wword   = '{last: in_last, data: in_data};

    ccsds123_fifo_mem #(.W($bits(word_t)), .DEPTH(DEPTH), .AW(AW)) u_mem (
        .clk     (clk),
        .i_we    (w_wr),
        .i_waddr (r_wptr),
        .i_wdata (w_wword),
        .i_raddr (r_rptr),
        .o_rdata (w_rword)
    );

    // Pending-lasts counter; a tlast can only leave while the tracker is in DRAIN.
    always_comb begin
        w_pend_nxt = r_pend;
        case ({w_wr && in_last, w_last_rd && (r_state == ST_DRAIN)})
            2'b10:   w_pend_nxt = r_pend + LW'(1);
            2'b01:   w_pend_nxt = r_pend - LW'(1);
            default: w_pend_nxt = r_pend;
        endcase
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_wptr        <= '0;
            r_rptr        <= '0;
            r_level       <= '0;
            r_pend        <= '0;
            r_state       <= ST_STREAM;
            r_cur         <= '0;
            r_frame_words <= '0;
            r_afull       <= 1'b0;
            r_ovf         <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            if (w_wr) r_wptr <= r_wptr + AW'(1);
            if (w_rd) r_rptr <= r_rptr + AW'(1);
            case ({w_wr, w_rd})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
            r_pend  <= w_pend_nxt;
            r_state <= (w_pend_nxt != '0) ? ST_DRAIN : ST_STREAM;
            // Registered on the pre-edge level, so it lags occupancy by one cycle.
            r_afull <= (r_level >= L_AFULL);
            if (w_drop) r_ovf <= 1'b1;
            r_done  <= w_last_rd;
            if (w_last_rd) begin
                r_frame_words <= (r_cur == CNT_MAX) ? CNT_MAX : r_cur + CNT_W'(1);
                r_cur         <= '0;
            end else if (w_rd && (r_cur != CNT_MAX)) begin
                r_cur <= r_cur + CNT_W'(1);
            end
        end
    end

    assign m_axis_tvalid = (r_level != '0);
    assign m_axis_tlast  = w_rword.last;
    assign almost_full   = r_afull;
    assign level         = r_level;
    assign overflow      = r_ovf;
    assign done          = r_done;
    assign frame_words   = r_frame_words;

`ifdef CCSDS123_OUT_BYTE_SWAP_EN
    for (genvar k = 0; k < BUS_WIDTH/8; k++) begin : g_swap
        assign m_axis_tdata[8*k +: 8] = w_rword.data[BUS_WIDTH-8-8*k +: 8];
    end
`else
    assign m_axis_tdata = w_rword.data;
`endif

endmodule
